// File: rtl/ysyx_25040129_rf_scheduler_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Holds the default register geometry and the writeback source enum.
package ysyx_25040129_rf_scheduler_pkg;

  localparam int REGS_DIG = 4;
  localparam int NREGS    = 2 ** REGS_DIG;
  localparam int XLEN     = 32;

  typedef enum logic {
    WB_EXU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/ysyx_25040129_rr_arb2.sv
// Two-way round-robin arbiter between EXU and LSU writeback requests.
// Grant is combinational; only the last-granted source is stored.
module ysyx_25040129_rr_arb2
  import ysyx_25040129_rf_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_exu,
  input  logic req_lsu,
  output logic gnt_exu,
  output logic gnt_lsu
);

  wb_src_e rr_last;

  always_comb begin
    gnt_exu = 1'b0;
    gnt_lsu = 1'b0;
    if (!rst) begin
      if (req_exu && req_lsu) begin
        // On a tie the source that did not win last time goes first.
        if (rr_last == WB_LSU) gnt_exu = 1'b1;
        else                   gnt_lsu = 1'b1;
      end else begin
        gnt_exu = req_exu;
        gnt_lsu = req_lsu;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= WB_LSU;
    end else if (gnt_exu) begin
      rr_last <= WB_EXU;
    end else if (gnt_lsu) begin
      rr_last <= WB_LSU;
    end
  end

endmodule

// File: rtl/ysyx_25040129_rf_scheduler.sv
// Register-file write-port scheduler: scoreboard-based RAW/WAW issue stall
// plus round-robin muxing of EXU/LSU writebacks onto the single write port.
module ysyx_25040129_rf_scheduler #(
  parameter int REGS_DIG = ysyx_25040129_rf_scheduler_pkg::REGS_DIG,
  parameter int XLEN     = ysyx_25040129_rf_scheduler_pkg::XLEN,
  localparam int NREGS   = 2 ** REGS_DIG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [REGS_DIG-1:0] iss_rd,
  input  logic                iss_rd_we,
  input  logic [REGS_DIG-1:0] iss_src1,
  input  logic [REGS_DIG-1:0] iss_src2,
  input  logic                exu_wb_valid,
  output logic                exu_wb_ready,
  input  logic [REGS_DIG-1:0] exu_wb_rd,
  input  logic [XLEN-1:0]     exu_wb_data,
  input  logic                lsu_wb_valid,
  output logic                lsu_wb_ready,
  input  logic [REGS_DIG-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]     lsu_wb_data,
  output logic                rf_we,
  output logic [REGS_DIG-1:0] rf_rd,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [NREGS-1:0]    busy_vec
);

  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    busy_next;
  logic                gnt_exu;
  logic                gnt_lsu;
  logic                gnt_any;
  logic [REGS_DIG-1:0] wb_rd;
  logic                set_en;
  logic                clr_en;

  ysyx_25040129_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_exu (exu_wb_valid),
    .req_lsu (lsu_wb_valid),
    .gnt_exu (gnt_exu),
    .gnt_lsu (gnt_lsu)
  );

  assign gnt_any      = gnt_exu || gnt_lsu;
  assign exu_wb_ready = gnt_exu;
  assign lsu_wb_ready = gnt_lsu;
  assign wb_rd        = gnt_lsu ? lsu_wb_rd : exu_wb_rd;

  // x0 writes complete the handshake but never reach the register file.
  assign rf_we    = gnt_any && (wb_rd != '0);
  assign rf_rd    = wb_rd;
  assign rf_wdata = gnt_lsu ? lsu_wb_data : exu_wb_data;

  // No bypass: a register being written this cycle still reads as busy.
  assign iss_ready = !rst && !busy[iss_src1] && !busy[iss_src2]
                     && !(iss_rd_we && busy[iss_rd]);

  assign set_en = iss_valid && iss_ready && iss_rd_we && (iss_rd != '0);
  assign clr_en = rf_we;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[wb_rd] = 1'b0;
    if (set_en) busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  // Protocol checks: writeback to an idle register, and set/clear collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) assert (busy[wb_rd]);
      if (set_en && clr_en) assert (iss_rd != wb_rd);
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_rf_scheduler.sv
// Directed bench for the register-file scheduler: reset, RAW/WAW stalls,
// arbitration order, x0 writes, and a short randomized run against a model.
module tb_ysyx_25040129_rf_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic        iss_ready;
  logic [3:0]  iss_rd;
  logic        iss_rd_we;
  logic [3:0]  iss_src1;
  logic [3:0]  iss_src2;
  logic        exu_wb_valid;
  logic        exu_wb_ready;
  logic [3:0]  exu_wb_rd;
  logic [31:0] exu_wb_data;
  logic        lsu_wb_valid;
  logic        lsu_wb_ready;
  logic [3:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        rf_we;
  logic [3:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [15:0] busy_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_25040129_rf_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rd       (iss_rd),
    .iss_rd_we    (iss_rd_we),
    .iss_src1     (iss_src1),
    .iss_src2     (iss_src2),
    .exu_wb_valid (exu_wb_valid),
    .exu_wb_ready (exu_wb_ready),
    .exu_wb_rd    (exu_wb_rd),
    .exu_wb_data  (exu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .busy_vec     (busy_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-12s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = 0; iss_rd_we = 0; iss_src1 = 0; iss_src2 = 0;
    exu_wb_valid = 0; exu_wb_rd = 0; exu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
  endtask

  task automatic issue(input logic [3:0] rd, input logic we, input logic [3:0] s1, input logic [3:0] s2);
    iss_valid = 1; iss_rd = rd; iss_rd_we = we; iss_src1 = s1; iss_src2 = s2;
  endtask

  function automatic logic [3:0] pick_busy(input logic [15:0] b, input logic [3:0] excl);
    int start;
    int idx;
    start = $urandom_range(0, 14);
    for (int k = 0; k < 15; k++) begin
      idx = 1 + ((start + k) % 15);
      if (b[idx] && (idx[3:0] != excl)) return idx[3:0];
    end
    return 4'd0;
  endfunction

  // Reference model state for the randomized section.
  logic [15:0] mb;
  logic        m_rr;       // 0: EXU granted last, 1: LSU granted last
  logic        ex_hold, ls_hold;
  logic [3:0]  ex_rd, ls_rd;
  logic [31:0] ex_data, ls_data;
  logic        exp_rdy, g_ex, g_ls;

  initial begin
    rst = 1;
    idle();

    // ---- 1: reset behaviour ----
    @(negedge clk);
    issue(4'd1, 1, 4'd0, 4'd0);
    exu_wb_valid = 1; exu_wb_rd = 4'd2; lsu_wb_valid = 1; lsu_wb_rd = 4'd3;
    #1;
    chk("rst_issrdy", iss_ready, 0);
    chk("rst_exurdy", exu_wb_ready, 0);
    chk("rst_lsurdy", lsu_wb_ready, 0);
    chk("rst_rfwe", rf_we, 0);
    chk("rst_busy", busy_vec, 0);
    @(negedge clk);
    idle();
    rst = 0;
    for (int r = 4; r < 8; r++) begin
      @(negedge clk);
      issue(r[3:0], 1, 4'd0, 4'd0);
      #1 chk("t1_issue", iss_ready, 1);
    end
    @(negedge clk);
    idle();
    #1 chk("t1_busyF0", busy_vec, 16'h00F0);
    exu_wb_valid = 1; exu_wb_rd = 4'd4; lsu_wb_valid = 1; lsu_wb_rd = 4'd5;
    issue(4'd1, 1, 4'd0, 4'd0);
    rst = 1;
    #1;
    chk("t1_busy0", busy_vec, 0);
    chk("t1_rfwe", rf_we, 0);
    chk("t1_exurdy", exu_wb_ready, 0);
    chk("t1_lsurdy", lsu_wb_ready, 0);
    chk("t1_issrdy", iss_ready, 0);
    @(negedge clk);
    idle();
    rst = 0;

    // ---- 2: RAW stall on x5 ----
    @(negedge clk);
    issue(4'd5, 1, 4'd0, 4'd0);
    #1 chk("t2_iss5", iss_ready, 1);
    @(negedge clk);
    issue(4'd1, 1, 4'd5, 4'd0);
    #1 chk("t2_raw", iss_ready, 0);
    @(negedge clk);
    exu_wb_valid = 1; exu_wb_rd = 4'd5; exu_wb_data = 32'h55;
    #1;
    chk("t2_rawwb", iss_ready, 0);
    chk("t2_exurdy", exu_wb_ready, 1);
    chk("t2_rfwe", rf_we, 1);
    chk("t2_rfrd", rf_rd, 5);
    chk("t2_rfdat", rf_wdata, 32'h55);
    @(negedge clk);
    exu_wb_valid = 0;
    #1 chk("t2_release", iss_ready, 1);
    @(negedge clk);
    idle();
    #1 chk("t2_busy", busy_vec, 16'h0002);
    exu_wb_valid = 1; exu_wb_rd = 4'd1; exu_wb_data = 32'h1;
    #1 chk("t2_clr1", exu_wb_ready, 1);
    @(negedge clk);
    idle();
    #1 chk("t2_busy0", busy_vec, 0);

    // ---- 3: WAW stall on x7 ----
    issue(4'd7, 1, 4'd0, 4'd0);
    #1 chk("t3_iss7", iss_ready, 1);
    @(negedge clk);
    issue(4'd7, 1, 4'd0, 4'd0);
    #1 chk("t3_waw", iss_ready, 0);
    @(negedge clk);
    lsu_wb_valid = 1; lsu_wb_rd = 4'd7; lsu_wb_data = 32'h77;
    #1;
    chk("t3_wawwb", iss_ready, 0);
    chk("t3_lsurdy", lsu_wb_ready, 1);
    chk("t3_rfrd", rf_rd, 7);
    chk("t3_rfdat", rf_wdata, 32'h77);
    @(negedge clk);
    lsu_wb_valid = 0;
    #1 chk("t3_release", iss_ready, 1);
    @(negedge clk);
    idle();
    #1 chk("t3_busy", busy_vec, 16'h0080);
    lsu_wb_valid = 1; lsu_wb_rd = 4'd7; lsu_wb_data = 32'h7;
    #1 chk("t3_clr7", lsu_wb_ready, 1);
    @(negedge clk);
    idle();

    // ---- 4: contention after reset ----
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    issue(4'd3, 1, 4'd0, 4'd0);
    #1 chk("t4_iss3", iss_ready, 1);
    @(negedge clk);
    issue(4'd4, 1, 4'd0, 4'd0);
    #1 chk("t4_iss4", iss_ready, 1);
    @(negedge clk);
    issue(4'd3, 1, 4'd0, 4'd0);
    exu_wb_valid = 1; exu_wb_rd = 4'd3; exu_wb_data = 32'h11;
    lsu_wb_valid = 1; lsu_wb_rd = 4'd4; lsu_wb_data = 32'h22;
    #1;
    chk("t4_c0_exu", exu_wb_ready, 1);
    chk("t4_c0_lsu", lsu_wb_ready, 0);
    chk("t4_c0_rd", rf_rd, 3);
    chk("t4_c0_dat", rf_wdata, 32'h11);
    chk("t4_c0_iss", iss_ready, 0);
    @(negedge clk);
    #1;
    chk("t4_c1_exu", exu_wb_ready, 0);
    chk("t4_c1_lsu", lsu_wb_ready, 1);
    chk("t4_c1_rd", rf_rd, 4);
    chk("t4_c1_dat", rf_wdata, 32'h22);
    chk("t4_c1_iss", iss_ready, 1);
    @(negedge clk);
    iss_valid = 0;
    #1;
    chk("t4_c2_exu", exu_wb_ready, 1);
    chk("t4_c2_lsu", lsu_wb_ready, 0);
    chk("t4_c2_rd", rf_rd, 3);
    chk("t4_c2_dat", rf_wdata, 32'h11);
    @(negedge clk);
    idle();
    #1 chk("t4_busy", busy_vec, 0);

    // ---- 5: x0 destination ----
    issue(4'd0, 1, 4'd0, 4'd0);
    #1 chk("t5_iss0", iss_ready, 1);
    @(negedge clk);
    idle();
    #1 chk("t5_busy_a", busy_vec, 0);
    exu_wb_valid = 1; exu_wb_rd = 4'd0; exu_wb_data = 32'hDEAD;
    #1;
    chk("t5_exurdy", exu_wb_ready, 1);
    chk("t5_rfwe", rf_we, 0);
    @(negedge clk);
    idle();
    #1 chk("t5_busy_b", busy_vec, 0);

    // ---- 6: randomized back-to-back traffic vs reference model ----
    mb = 16'h0; m_rr = 1'b0;
    ex_hold = 0; ls_hold = 0; ex_rd = 0; ls_rd = 0; ex_data = 0; ls_data = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      #1 chk("t6_busy", busy_vec, mb);
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 4'($urandom_range(0, 15));
      iss_rd_we = ($urandom_range(0, 3) != 0);
      iss_src1  = 4'($urandom_range(0, 15));
      iss_src2  = 4'($urandom_range(0, 15));
      if (!ex_hold && $urandom_range(0, 1) == 1) begin
        ex_hold = 1; ex_rd = pick_busy(mb, ls_hold ? ls_rd : 4'd0); ex_data = $urandom;
      end
      if (!ls_hold && $urandom_range(0, 1) == 1) begin
        ls_hold = 1; ls_rd = pick_busy(mb, ex_hold ? ex_rd : 4'd0); ls_data = $urandom;
      end
      exu_wb_valid = ex_hold; exu_wb_rd = ex_rd; exu_wb_data = ex_data;
      lsu_wb_valid = ls_hold; lsu_wb_rd = ls_rd; lsu_wb_data = ls_data;
      exp_rdy = !mb[iss_src1] && !mb[iss_src2] && !(iss_rd_we && mb[iss_rd]);
      g_ex = ex_hold && (!ls_hold || m_rr);
      g_ls = ls_hold && !g_ex;
      #1;
      chk("t6_issrdy", iss_ready, exp_rdy);
      chk("t6_exurdy", exu_wb_ready, g_ex);
      chk("t6_lsurdy", lsu_wb_ready, g_ls);
      if (g_ex) begin
        chk("t6_rfwe", rf_we, ex_rd != 0);
        chk("t6_rfrd", rf_rd, ex_rd);
        chk("t6_rfdat", rf_wdata, ex_data);
        if (ex_rd != 0) mb[ex_rd] = 1'b0;
        m_rr = 1'b0; ex_hold = 0;
      end else if (g_ls) begin
        chk("t6_rfwe", rf_we, ls_rd != 0);
        chk("t6_rfrd", rf_rd, ls_rd);
        chk("t6_rfdat", rf_wdata, ls_data);
        if (ls_rd != 0) mb[ls_rd] = 1'b0;
        m_rr = 1'b1; ls_hold = 0;
      end else begin
        chk("t6_rfwe", rf_we, 0);
      end
      if (iss_valid && exp_rdy && iss_rd_we && iss_rd != 0) mb[iss_rd] = 1'b1;
    end
    @(negedge clk);
    idle();
    #1 chk("t6_busyend", busy_vec, mb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
